// File: rtl/dmem_mmio.sv
// Data-side memory stage: word RAM plus a memory-mapped I/O page (LED, switches,
// cycle counter, countdown timer with sticky expiry). Reads are combinational.
module dmem_mmio #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
  parameter int unsigned SW_WIDTH  = 10,
  parameter int unsigned LED_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memwrite,
  input  logic [31:0]          addr,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic                 timer_irq,
  output logic                 addr_err
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

  typedef enum logic [5:0] {
    REG_LED    = 6'h00,
    REG_SW     = 6'h01,
    REG_CYCLES = 6'h02,
    REG_TIMER  = 6'h03,
    REG_STATUS = 6'h04
  } mmio_reg_e;

  logic [31:0]          r_mem [DEPTH];
  logic [LED_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0]  r_sync1;
  logic [SW_WIDTH-1:0]  r_sync2;
  logic [31:0]          r_cycles;
  logic [31:0]          r_timer;
  logic                 r_expired;
  logic                 r_addr_err;

  logic                 w_is_ram;
  logic                 w_is_page;
  logic                 w_reg_hit;
  logic                 w_unmapped;
  logic [AW-1:0]        w_word;
  mmio_reg_e            w_reg;
  logic                 w_wr_led;
  logic                 w_wr_cycles;
  logic                 w_wr_timer;
  logic                 w_wr_status;
  logic                 w_expire;

  always_comb begin
    w_is_ram    = (addr < RAM_BYTES);
    w_is_page   = !w_is_ram && (addr[31:8] == MMIO_BASE[31:8]);
    w_reg       = mmio_reg_e'(addr[7:2]);
    w_word      = addr[AW+1:2];
    w_reg_hit   = w_is_page && (w_reg <= REG_STATUS);
    w_unmapped  = !w_is_ram && !w_reg_hit;
    w_wr_led    = memwrite && w_reg_hit && (w_reg == REG_LED);
    w_wr_cycles = memwrite && w_reg_hit && (w_reg == REG_CYCLES);
    w_wr_timer  = memwrite && w_reg_hit && (w_reg == REG_TIMER);
    w_wr_status = memwrite && w_reg_hit && (w_reg == REG_STATUS);
    // A timer load in the same cycle pre-empts the 1->0 step, so no expiry then.
    w_expire    = !w_wr_timer && (r_timer == 32'd1);
  end

  always_comb begin
    readdata = '0;
    if (w_is_ram) begin
      readdata = r_mem[w_word];
    end else if (w_reg_hit) begin
      case (w_reg)
        REG_LED:    readdata = 32'(r_led);
        REG_SW:     readdata = 32'(r_sync2);
        REG_CYCLES: readdata = r_cycles;
        REG_TIMER:  readdata = r_timer;
        REG_STATUS: readdata = {31'd0, r_expired};
        default:    readdata = '0;
      endcase
    end
  end

  // RAM contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (memwrite && w_is_ram) begin
      r_mem[w_word] <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led      <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_cycles   <= '0;
      r_timer    <= '0;
      r_expired  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;

      if (w_wr_led) begin
        r_led <= writedata[LED_WIDTH-1:0];
      end

      r_cycles <= w_wr_cycles ? '0 : r_cycles + 32'd1;

      if (w_wr_timer) begin
        r_timer <= writedata;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 32'd1;
      end

      // Expiry has priority over a coincident software clear.
      if (w_expire) begin
        r_expired <= 1'b1;
      end else if (w_wr_status && writedata[0]) begin
        r_expired <= 1'b0;
      end

      if (w_unmapped) begin
        r_addr_err <= 1'b1;
      end
    end
  end

  assign led_out   = r_led;
  assign timer_irq = r_expired;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboarded random + directed bench for dmem_mmio against a behavioural model.
module tb_dmem_mmio;

  localparam int unsigned DEPTH  = 64;
  localparam logic [31:0] BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] A_LED  = BASE + 32'h00;
  localparam logic [31:0] A_SW   = BASE + 32'h04;
  localparam logic [31:0] A_CYC  = BASE + 32'h08;
  localparam logic [31:0] A_TMR  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  sw_in;
  logic [9:0]  led_out;
  logic        timer_irq;
  logic        addr_err;

  dmem_mmio #(
    .DEPTH    (DEPTH),
    .MMIO_BASE(BASE),
    .SW_WIDTH (10),
    .LED_WIDTH(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .sw_in    (sw_in),
    .led_out  (led_out),
    .timer_irq(timer_irq),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [9:0]  led;
    logic        irq;
    logic        aerr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural reference state
  logic [31:0] m_mem [DEPTH];
  logic [9:0]  m_led, m_s1, m_s2;
  logic [31:0] m_cyc, m_tmr;
  logic        m_exp, m_aerr;

  function automatic bit m_ram(logic [31:0] a);
    return a < DEPTH * 4;
  endfunction

  function automatic int unsigned m_off(logic [31:0] a);
    return (a & 32'hFF) >> 2;
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    return !m_ram(a) && ((a >> 8) == (BASE >> 8)) && (m_off(a) <= 4);
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (m_ram(a)) return m_mem[a >> 2];
    if (!m_hit(a)) return 32'h0;
    case (m_off(a))
      0:       return {22'd0, m_led};
      1:       return {22'd0, m_s2};
      2:       return m_cyc;
      3:       return m_tmr;
      default: return {31'd0, m_exp};
    endcase
  endfunction

  task automatic m_reset();
    m_led = '0; m_s1 = '0; m_s2 = '0;
    m_cyc = '0; m_tmr = '0; m_exp = 1'b0; m_aerr = 1'b0;
  endtask

  task automatic m_step(bit we, logic [31:0] a, logic [31:0] wd, logic [9:0] sw);
    bit hit   = m_hit(a);
    int unsigned off = m_off(a);
    bit tload = we && hit && off == 3;
    bit fire  = !tload && m_tmr == 32'd1;
    if (we && m_ram(a)) m_mem[a >> 2] = wd;
    if (we && hit && off == 0) m_led = wd[9:0];
    m_cyc = (we && hit && off == 2) ? 32'd0 : m_cyc + 32'd1;
    if (tload) m_tmr = wd;
    else if (m_tmr != 0) m_tmr = m_tmr - 32'd1;
    if (fire) m_exp = 1'b1;
    else if (we && hit && off == 4 && wd[0]) m_exp = 1'b0;
    if (!m_ram(a) && !hit) m_aerr = 1'b1;
    m_s2 = m_s1;
    m_s1 = sw;
  endtask

  task automatic push(string nm);
    exp_t e;
    e.name = nm;
    e.rd   = m_read(addr);
    e.led  = m_led;
    e.irq  = m_exp;
    e.aerr = m_aerr;
    q.push_back(e);
  endtask

  task automatic cyc(string nm, bit we, logic [31:0] a, logic [31:0] wd);
    memwrite  = we;
    addr      = a;
    writedata = wd;
    push(nm);
    @(posedge clk);
    if (reset) m_step(we, a, wd, sw_in);
    #1;
  endtask

  task automatic check(string nm, string fld, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check(e.name, "readdata", readdata, e.rd);
      check(e.name, "led_out", {22'd0, led_out}, {22'd0, e.led});
      check(e.name, "timer_irq", {31'd0, timer_irq}, {31'd0, e.irq});
      check(e.name, "addr_err", {31'd0, addr_err}, {31'd0, e.aerr});
    end
  end

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit expired");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] a, wd;
    bit          we;
    int unsigned k;

    reset = 1'b0; memwrite = 1'b0; addr = A_TMR; writedata = '0; sw_in = '0;
    m_reset();
    @(posedge clk); #1;
    push("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) cyc("ram_init", 1'b1, 32'(i * 4), $urandom);

    cyc("ram_wr", 1'b1, 32'h10, 32'hDEAD_BEEF);
    cyc("ram_rd10", 1'b0, 32'h10, '0);
    cyc("ram_rd13", 1'b0, 32'h13, '0);

    cyc("led_wr", 1'b1, A_LED, 32'hFFFF_FFFF);
    cyc("led_rd", 1'b0, A_LED, '0);
    sw_in = 10'h155;
    cyc("sw_edge0", 1'b0, A_SW, '0);
    cyc("sw_edge1", 1'b0, A_SW, '0);
    cyc("sw_edge2", 1'b0, A_SW, '0);
    cyc("sw_wr_ignored", 1'b1, A_SW, 32'hFFFF_FFFF);
    cyc("sw_rd", 1'b0, A_SW, '0);

    cyc("cyc_wr", 1'b1, A_CYC, 32'd123);
    for (int i = 0; i < 6; i++) cyc("cyc_count", 1'b0, A_CYC, '0);
    force dut.r_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycles;
    m_cyc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) cyc("cyc_wrap", 1'b0, A_CYC, '0);

    cyc("tmr_load3", 1'b1, A_TMR, 32'd3);
    for (int i = 0; i < 5; i++) cyc("tmr_count", 1'b0, A_TMR, '0);
    cyc("stat_wr0", 1'b1, A_STAT, 32'd0);
    cyc("stat_keep", 1'b0, A_STAT, '0);
    cyc("stat_clr", 1'b1, A_STAT, 32'd1);
    cyc("stat_rd", 1'b0, A_STAT, '0);
    cyc("tmr_load0", 1'b1, A_TMR, 32'd0);
    cyc("tmr_load0_rd", 1'b0, A_STAT, '0);
    cyc("tmr_load0_rd", 1'b0, A_STAT, '0);
    cyc("coin_load2", 1'b1, A_TMR, 32'd2);
    cyc("coin_rd", 1'b0, A_TMR, '0);
    cyc("coin_clr", 1'b1, A_STAT, 32'd1);
    cyc("coin_set_wins", 1'b0, A_STAT, '0);
    cyc("lw_clr", 1'b1, A_STAT, 32'd1);
    cyc("lw_load2", 1'b1, A_TMR, 32'd2);
    cyc("lw_rd", 1'b0, A_TMR, '0);
    cyc("lw_reload0", 1'b1, A_TMR, 32'd0);
    cyc("lw_no_expire", 1'b0, A_STAT, '0);
    cyc("lw_no_expire", 1'b0, A_TMR, '0);

    cyc("unm_wr", 1'b1, 32'h8000_0000, 32'h1234_5678);
    cyc("unm_led", 1'b0, A_LED, '0);
    cyc("unm_ram", 1'b0, 32'h10, '0);
    cyc("unm_page", 1'b0, BASE + 32'h14, '0);
    cyc("unm_hold", 1'b0, A_STAT, '0);

    cyc("rst_tmr", 1'b1, A_TMR, 32'd100);
    cyc("rst_led", 1'b1, A_LED, 32'h2A);
    memwrite = 1'b0; addr = A_TMR; writedata = '0;
    #2;
    reset = 1'b0;
    m_reset();
    #1;
    push("rst_async");
    @(posedge clk); #1;
    addr = A_LED;
    push("rst_hold");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) cyc("rst_cyc", 1'b0, A_CYC, '0);
    cyc("rst_tmr_rd", 1'b0, A_TMR, '0);

    for (int i = 0; i < 400; i++) begin
      k     = $urandom_range(0, 9);
      sw_in = 10'($urandom);
      we    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      if (k <= 3) begin
        a = $urandom_range(0, DEPTH * 4 - 1);
      end else if (k <= 7) begin
        a  = BASE + 4 * $urandom_range(0, 4) + $urandom_range(0, 3);
        we = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 1) == 1) wd = $urandom_range(0, 6);
      end else if (k == 8) begin
        a = BASE + 4 * $urandom_range(5, 63);
      end else begin
        a = $urandom;
      end
      cyc("random", we, a, wd);
    end

    memwrite = 1'b0;
    addr = 32'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
